// File: rtl/ctr_link_pkg.sv
// Shared types for the PLD control link.
// Used by the host transmitter, the PLD-side model and benches.
package ctr_link_pkg;

  localparam int CTR_WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HI,
    LO,
    GAP
  } ctr_state_e;

  typedef logic [CTR_WORD_W-1:0] ctr_word_t;

endpackage

// File: rtl/ctr_tx_fifo.sv
// Word buffer in front of the control-link serialiser.
// Flags reflect state before any same-cycle push/pop.
module ctr_tx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_ok;
  logic             rd_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rd_data = mem[rd_ptr];
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;

  // Pointers, occupancy and the sticky drop flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_en && full) ovf <= 1'b1;
    end
  end

  // Storage array; contents need no reset
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ctr_link_tx.sv
// Host-side serialiser for the PLD control link.
// Frames each buffered word MSB first on ctr_clock/ctr_data/ctr_sync.
module ctr_link_tx
  import ctr_link_pkg::*;
#(
  parameter int WORD_W     = CTR_WORD_W,
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [WORD_W-1:0]             wr_data,
  input  logic                          wr_en,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          ovf,
  output logic                          busy,
  output logic                          word_done,
  input  logic                          gate_in,
  output logic                          ctr_clock,
  output logic                          ctr_data,
  output logic                          ctr_sync,
  output logic                          ctr_feedback
);

  localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int DW      = $clog2(CNT_MAX + 1);
  localparam int BW      = $clog2(WORD_W);

  ctr_state_e        state;
  ctr_state_e        state_n;
  logic [DW-1:0]     div;
  logic [BW-1:0]     bit_cnt;
  logic [BW-1:0]     bit_n;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] shreg_n;
  logic [WORD_W-1:0] rd_data;
  logic              empty;
  logic              pop;
  logic              phase_end;
  logic              gap_end;
  logic              bits_left;
  logic              clock_n;
  logic              sync_n;
  logic              done_n;

  ctr_tx_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (level),
    .ovf     (ovf)
  );

  assign phase_end = (div == DW'(CLK_DIV - 1));
  assign gap_end   = (div == DW'(GAP_CYCLES - 1));
  assign bits_left = (bit_cnt != '0);
  assign busy      = (state != IDLE);
  // The current bit is the shift register MSB, so the pin is a flop output
  assign ctr_data  = shreg[WORD_W-1];

  // State, phase divider, bit counter and pin registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      div       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      ctr_clock <= 1'b0;
      ctr_sync  <= 1'b1;
      word_done <= 1'b0;
    end else begin
      state     <= state_n;
      div       <= (state_n != state || state == IDLE) ? '0 : div + 1'b1;
      bit_cnt   <= bit_n;
      shreg     <= shreg_n;
      ctr_clock <= clock_n;
      ctr_sync  <= sync_n;
      word_done <= done_n;
    end
  end

  // Next-state decode
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (!empty)   state_n = SETUP;
      SETUP:   if (phase_end) state_n = HI;
      HI:      if (phase_end) state_n = LO;
      LO:      if (phase_end) state_n = bits_left ? HI : GAP;
      GAP:     if (gap_end)   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next values for the pins, shifter and bit counter
  always_comb begin
    pop     = 1'b0;
    clock_n = ctr_clock;
    sync_n  = ctr_sync;
    done_n  = 1'b0;
    shreg_n = shreg;
    bit_n   = bit_cnt;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shreg_n = rd_data;
          bit_n   = BW'(WORD_W - 1);
          sync_n  = 1'b0;
          clock_n = 1'b0;
        end
      end
      SETUP: begin
        if (phase_end) clock_n = 1'b1;
      end
      HI: begin
        if (phase_end) begin
          clock_n = 1'b0;
          if (bits_left) shreg_n = {shreg[WORD_W-2:0], 1'b0};
        end
      end
      LO: begin
        if (phase_end) begin
          if (bits_left) begin
            clock_n = 1'b1;
            bit_n   = bit_cnt - 1'b1;
          end else begin
            sync_n  = 1'b1;
            done_n  = 1'b1;
            shreg_n = '0;
          end
        end
      end
      GAP: begin
      end
      default: begin
      end
    endcase
  end

  // Burst gate passthrough, one cycle late and independent of framing
  always_ff @(posedge clk) begin
    if (reset) ctr_feedback <= 1'b0;
    else       ctr_feedback <= gate_in;
  end

endmodule

// File: tb/tb_ctr_link_tx.sv
// Directed bench for ctr_link_tx.
// A PLD-side shift-in model decodes every frame on ctr_clock rises.
module tb_ctr_link_tx;
  import ctr_link_pkg::*;

  localparam int W        = CTR_WORD_W;
  localparam int DIV      = 4;
  localparam int DEPTH    = 16;
  localparam int GAPC     = 4;
  localparam int SYNC_LOW = DIV * (1 + 2 * W);

  logic                      clk = 1'b0;
  logic                      reset;
  logic [W-1:0]              wr_data;
  logic                      wr_en;
  logic                      full;
  logic [$clog2(DEPTH):0]    level;
  logic                      ovf;
  logic                      busy;
  logic                      word_done;
  logic                      gate_in;
  logic                      ctr_clock;
  logic                      ctr_data;
  logic                      ctr_sync;
  logic                      ctr_feedback;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  ctr_link_tx #(
    .WORD_W     (W),
    .CLK_DIV    (DIV),
    .FIFO_DEPTH (DEPTH),
    .GAP_CYCLES (GAPC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .full         (full),
    .level        (level),
    .ovf          (ovf),
    .busy         (busy),
    .word_done    (word_done),
    .gate_in      (gate_in),
    .ctr_clock    (ctr_clock),
    .ctr_data     (ctr_data),
    .ctr_sync     (ctr_sync),
    .ctr_feedback (ctr_feedback)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // PLD-side receiver model
  logic [W-1:0] rx_sh = '0;
  int           rx_bits = 0;
  int           rises = 0;
  ctr_word_t    rx_q[$];

  always @(posedge ctr_clock) begin
    rises = rises + 1;
    if (ctr_sync === 1'b0) begin
      rx_sh   = {rx_sh[W-2:0], ctr_data};
      rx_bits = rx_bits + 1;
    end
  end

  always @(negedge ctr_sync) rx_bits = 0;

  always @(posedge ctr_sync) begin
    if (rx_bits == W) rx_q.push_back(rx_sh);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sync(input logic v, input int lim, output bit ok);
    int n = 0;
    while (ctr_sync !== v && n < lim) begin
      tick();
      n++;
    end
    ok = (ctr_sync === v);
  endtask

  task automatic wait_done(input int lim, output bit ok);
    int n = 0;
    while (word_done !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    ok = (word_done === 1'b1);
  endtask

  task automatic wait_idle(input int lim, output bit ok);
    int n = 0;
    while (busy !== 1'b0 && n < lim) begin
      tick();
      n++;
    end
    ok = (busy === 1'b0);
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    gate_in = 1'b0;
    repeat (3) tick();
    n_cmp++; if (ctr_sync !== 1'b1) begin n_bad++; $display("FAIL rst_sync got %b want 1", ctr_sync); end
    n_cmp++; if (ctr_clock !== 1'b0) begin n_bad++; $display("FAIL rst_clock got %b want 0", ctr_clock); end
    n_cmp++; if (ctr_data !== 1'b0) begin n_bad++; $display("FAIL rst_data got %b want 0", ctr_data); end
    n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL rst_level got %0d want 0", level); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL rst_ovf got %b want 0", ovf); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL rst_full got %b want 0", full); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (word_done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", word_done); end
    n_cmp++; if (ctr_feedback !== 1'b0) begin n_bad++; $display("FAIL rst_fb got %b want 0", ctr_feedback); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int t0, tf, td, r0;
    bit ok;
    rx_q.delete();
    wr_data = 32'hA5C3_0F81;
    wr_en   = 1'b1;
    t0      = cyc;
    tick();
    wr_en = 1'b0;
    wait_sync(1'b0, 10, ok);
    tf = cyc;
    r0 = rises;
    n_cmp++; if (!ok || tf - t0 != 2) begin n_bad++; $display("FAIL single_latency got %0d want 2", tf - t0); end
    wait_done(400, ok);
    td = cyc;
    n_cmp++; if (!ok || td - tf != SYNC_LOW) begin n_bad++; $display("FAIL single_done_time got %0d want %0d", td - tf, SYNC_LOW); end
    n_cmp++; if (ctr_sync !== 1'b1) begin n_bad++; $display("FAIL single_sync_end got %b want 1", ctr_sync); end
    n_cmp++; if (rises - r0 != W) begin n_bad++; $display("FAIL single_rises got %0d want %0d", rises - r0, W); end
    n_cmp++; if (rx_q.size() != 1) begin n_bad++; $display("FAIL single_count got %0d want 1", rx_q.size()); end
    else if (rx_q[0] !== 32'hA5C3_0F81) begin n_bad++; $display("FAIL single_word got %h want a5c30f81", rx_q[0]); end
    tick();
    n_cmp++; if (word_done !== 1'b0) begin n_bad++; $display("FAIL single_pulse got %b want 0", word_done); end
    wait_idle(20, ok);
    n_cmp++; if (!ok || cyc - td != GAPC) begin n_bad++; $display("FAIL single_gap got %0d want %0d", cyc - td, GAPC); end
    rx_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w [3];
    int td, hi;
    bit ok;
    w[0] = 32'h1234_5678;
    w[1] = 32'hDEAD_BEEF;
    w[2] = 32'h0F0F_F0F0;
    for (int i = 0; i < 3; i++) begin
      wr_data = w[i];
      wr_en   = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    n_cmp++; if (level !== 5'd2) begin n_bad++; $display("FAIL b2b_level0 got %0d want 2", level); end
    td = 0;
    for (int i = 0; i < 3; i++) begin
      wait_sync(1'b0, 20, ok);
      if (i > 0) begin
        hi = cyc - td;
        n_cmp++; if (!ok || hi < GAPC) begin n_bad++; $display("FAIL b2b_gap%0d got %0d want >=%0d", i, hi, GAPC); end
        n_cmp++; if (level !== 5'(2 - i)) begin n_bad++; $display("FAIL b2b_level%0d got %0d want %0d", i, level, 2 - i); end
      end
      wait_done(400, ok);
      td = cyc;
    end
    wait_idle(20, ok);
    n_cmp++; if (rx_q.size() != 3) begin n_bad++; $display("FAIL b2b_count got %0d want 3", rx_q.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++; if (rx_q[i] !== w[i]) begin n_bad++; $display("FAIL b2b_word%0d got %h want %h", i, rx_q[i], w[i]); end
      end
    end
    rx_q.delete();
  endtask

  task automatic test_overflow();
    bit ok;
    for (int i = 0; i < 18; i++) begin
      wr_data = 32'hC000_0000 | 32'(i);
      wr_en   = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    n_cmp++; if (level !== 5'd16) begin n_bad++; $display("FAIL ovf_level got %0d want 16", level); end
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL ovf_full got %b want 1", full); end
    n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b want 1", ovf); end
    wait_done(400, ok);
    n_cmp++; if (!ok || full !== 1'b1 || ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_hold got full=%b ovf=%b want 1 1", full, ovf); end
    wait_sync(1'b0, 20, ok);
    n_cmp++; if (!ok || full !== 1'b0 || level !== 5'd15) begin n_bad++; $display("FAIL ovf_pop got full=%b level=%0d want 0 15", full, level); end
    n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %b want 1", ovf); end
    n_cmp++; if (rx_q.size() != 1 || rx_q[0] !== 32'hC000_0000) begin n_bad++; $display("FAIL ovf_first got n=%0d want c0000000", rx_q.size()); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int q0, r0;
    bit ok;
    while (rx_bits < 10 && n < 200) begin
      tick();
      n++;
    end
    n_cmp++; if (rx_bits != 10) begin n_bad++; $display("FAIL mid_reach got %0d want 10", rx_bits); end
    q0 = rx_q.size();
    reset = 1'b1;
    tick();
    n_cmp++; if (ctr_sync !== 1'b1 || ctr_clock !== 1'b0) begin n_bad++; $display("FAIL mid_pins got sync=%b clk=%b want 1 0", ctr_sync, ctr_clock); end
    n_cmp++; if (level !== 5'd0 || full !== 1'b0 || ovf !== 1'b0) begin n_bad++; $display("FAIL mid_fifo got level=%0d full=%b ovf=%b want 0 0 0", level, full, ovf); end
    reset = 1'b0;
    r0 = rises;
    repeat (20) tick();
    n_cmp++; if (rises != r0 || ctr_sync !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL mid_quiet got rises=%0d sync=%b want 0 1", rises - r0, ctr_sync); end
    n_cmp++; if (rx_q.size() != q0) begin n_bad++; $display("FAIL mid_partial got %0d want %0d", rx_q.size(), q0); end
    rx_q.delete();
    wr_data = 32'h0000_0001;
    wr_en   = 1'b1;
    tick();
    wr_en = 1'b0;
    wait_done(400, ok);
    n_cmp++; if (!ok || rx_q.size() != 1 || rx_q[0] !== 32'h0000_0001) begin n_bad++; $display("FAIL mid_resend got n=%0d want word 00000001", rx_q.size()); end
    wait_idle(20, ok);
    rx_q.delete();
  endtask

  task automatic test_gate();
    logic [7:0] pat;
    logic       prev;
    bit         ok;
    pat     = 8'b1011_0010;
    wr_data = 32'h3C5A_96E1;
    wr_en   = 1'b1;
    tick();
    wr_en = 1'b0;
    wait_sync(1'b0, 10, ok);
    repeat (7) tick();
    for (int k = 0; k < 8; k++) begin
      prev    = gate_in;
      gate_in = pat[k];
      #1;
      n_cmp++; if (ctr_feedback !== prev) begin n_bad++; $display("FAIL gate_early%0d got %b want %b", k, ctr_feedback, prev); end
      tick();
      n_cmp++; if (ctr_feedback !== pat[k]) begin n_bad++; $display("FAIL gate_follow%0d got %b want %b", k, ctr_feedback, pat[k]); end
    end
    gate_in = 1'b0;
    wait_done(400, ok);
    n_cmp++; if (!ok || rx_q.size() != 1 || rx_q[0] !== 32'h3C5A_96E1) begin n_bad++; $display("FAIL gate_word got n=%0d want word 3c5a96e1", rx_q.size()); end
    wait_idle(20, ok);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_gate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
